// File: rtl/number_stream_source_if.sv
// Load/playback port bundle of the number stream source.
// The master side is the stream source; the slave side loads the table,
// starts playback and watches the next/number strobes.
interface number_stream_source_if;
    logic       clr;
    logic       wr_en;
    logic [7:0] wr_value;
    logic [7:0] wr_count;
    logic       start;
    logic       next;
    logic [7:0] number;
    logic       busy;
    logic       done;
    logic       full;
    logic [7:0] expected_mode;

    modport master (
        input  clr, wr_en, wr_value, wr_count, start,
        output next, number, busy, done, full, expected_mode
    );

    modport slave (
        output clr, wr_en, wr_value, wr_count, start,
        input  next, number, busy, done, full, expected_mode
    );
endinterface

// File: rtl/number_stream_source.sv
// number_stream_source: plays a loaded table of (value, repeat-count) entries
// as a paced stream of next strobes with number valid. It also tracks the
// value whose count is largest (later entry wins ties) as the expected mode.
// All outputs are registered from the next-state decode, so the first pulse
// appears in the cycle right after start is sampled.
module number_stream_source #(
    parameter int DEPTH = 16,
    parameter int GAP   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    number_stream_source_if.master bus
);

    localparam int AW         = $clog2(DEPTH);
    localparam int PW         = AW + 1;
    localparam int GW         = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int GAP_LAST_I = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LAST_I);

    typedef enum logic [1:0] {IDLE, EMIT, WAIT, FIN} state_t;

    state_t state;
    state_t state_n;

    logic [7:0] value_mem [DEPTH];
    logic [7:0] count_mem [DEPTH];

    // wptr ranges 0..DEPTH, so its top bit doubles as the full flag
    logic [PW-1:0] wptr;
    logic [7:0]    best_count;
    logic [7:0]    mode;

    logic [PW-1:0] idx;
    logic [PW-1:0] idx_n;
    logic [7:0]    rep;
    logic [7:0]    rep_n;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_cnt_n;

    logic       next_q;
    logic       next_d;
    logic [7:0] number_q;
    logic [7:0] number_d;
    logic       busy_q;
    logic       busy_d;
    logic       done_q;
    logic       done_d;

    logic          idle;
    logic          load_ok;
    logic [7:0]    cur_count;
    logic [PW-1:0] idx_inc;
    logic [7:0]    rep_inc;
    logic          last_rep;

    assign idle      = (state == IDLE);
    assign load_ok   = idle && bus.wr_en && !bus.clr && !wptr[AW];
    assign cur_count = count_mem[idx[AW-1:0]];
    assign idx_inc   = idx + PW'(1);
    assign rep_inc   = rep + 8'd1;
    assign last_rep  = (rep_inc == cur_count);

    // Table storage: plain data, written only by an accepted load
    always_ff @(posedge clk) begin
        if (load_ok) begin
            value_mem[wptr[AW-1:0]] <= bus.wr_value;
            count_mem[wptr[AW-1:0]] <= bus.wr_count;
        end
    end

    // Write pointer and running mode tracker; a clear beats a same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            best_count <= '0;
            mode       <= '0;
        end else if (idle && bus.clr) begin
            wptr       <= '0;
            best_count <= '0;
            mode       <= '0;
        end else if (load_ok) begin
            wptr <= wptr + PW'(1);
            if (bus.wr_count >= best_count) begin
                best_count <= bus.wr_count;
                mode       <= bus.wr_value;
            end
        end
    end

    // Playback sequencing: walk entries, repeats and gap cycles
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        rep_n     = rep;
        gap_cnt_n = gap_cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    idx_n     = '0;
                    rep_n     = '0;
                    gap_cnt_n = '0;
                    state_n   = (wptr == '0) ? FIN : EMIT;
                end
            end
            EMIT: begin
                if (cur_count == 8'd0) begin
                    // Zero-count entry costs one silent cycle
                    idx_n   = idx_inc;
                    rep_n   = '0;
                    state_n = (idx_inc == wptr) ? FIN : EMIT;
                end else begin
                    if (last_rep) begin
                        idx_n = idx_inc;
                        rep_n = '0;
                    end else begin
                        rep_n = rep_inc;
                    end
                    gap_cnt_n = '0;
                    // With a gap, the end-of-table check happens after the wait
                    if (GAP > 0) begin
                        state_n = WAIT;
                    end else if (last_rep && (idx_inc == wptr)) begin
                        state_n = FIN;
                    end else begin
                        state_n = EMIT;
                    end
                end
            end
            WAIT: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = (idx == wptr) ? FIN : EMIT;
                end else begin
                    gap_cnt_n = gap_cnt + GW'(1);
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output decode for the cycle described by the next state
    always_comb begin
        next_d   = 1'b0;
        number_d = number_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_n)
            EMIT: begin
                busy_d = 1'b1;
                if (count_mem[idx_n[AW-1:0]] != 8'd0) begin
                    next_d   = 1'b1;
                    number_d = value_mem[idx_n[AW-1:0]];
                end
            end
            WAIT: begin
                busy_d = 1'b1;
            end
            FIN: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State and playback counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            rep     <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            rep     <= rep_n;
            gap_cnt <= gap_cnt_n;
        end
    end

    // Registered stream outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            next_q   <= 1'b0;
            number_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            next_q   <= next_d;
            number_q <= number_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.next          = next_q;
    assign bus.number        = number_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.full          = wptr[AW];
    assign bus.expected_mode = mode;

endmodule
